// File: rtl/sha256_pkg.sv
// sha256_pkg
// Purpose : Shared SHA-256 constants, controller state encoding and the
//           FIPS 180-4 bitwise helper functions.
// Contents: state_t  - controller states
//           K        - 64 round constants
//           H_INIT   - initial hash value, H0 in the first (most significant) slot
//           rotr, ch, maj, big_sigma0/1, small_sigma0/1
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_PAD,
        ST_LOAD,
        ST_ROUND,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Index 0 is the most significant word so the packed array doubles as the digest layout.
    localparam logic [0:7][31:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// Purpose : 16-word sliding window that produces the message schedule W[t]
//           one word per round.
// Ports   : clk        - clock, rising edge
//           rst_n      - synchronous reset, active-low
//           load       - replace the window with load_words (W[0..15])
//           shift      - advance the window by one word
//           load_words - 16 big-endian block words, word 0 first
//           w_t        - schedule word for the current round (window slot 0)
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [0:15][31:0] load_words,
    output logic [31:0]      w_t
);

    logic [0:15][31:0] window_q;
    logic [0:15][31:0] window_d;

    // Slot 0 always holds W[t]. Shifting drops it and appends W[t+16], which
    // depends only on words still inside the window (slots 0, 1, 9 and 14).
    always_comb begin
        window_d = window_q;
        if (load) begin
            window_d = load_words;
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                window_d[i] = window_q[i + 1];
            end
            window_d[15] = small_sigma1(window_q[14]) + window_q[9]
                         + small_sigma0(window_q[1]) + window_q[0];
        end
    end

    // Window register, cleared on reset so a reset mid-hash leaves no stale state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

    assign w_t = window_q[0];

endmodule

// File: rtl/sha256_multiblock_core.sv
// sha256_multiblock_core
// Purpose : Iterative SHA-256 engine, one round per clock. Accepts a raw
//           left-aligned message plus its bit length, pads it internally and
//           returns the 256-bit digest after 1+66*N cycles (N padded blocks).
// Ports   : clk     - clock, rising edge
//           rst_n   - synchronous reset, active-low
//           start   - hash request, only looked at while idle
//           msg     - message, msg[0] is the first bit (MSB of first byte)
//           msg_len - message length in bits
//           busy    - hash in progress
//           done    - one-cycle pulse, digest valid
//           len_err - one-cycle pulse, message too long to pad, nothing hashed
//           digest  - H0..H7, H0 in [255:224], held between results
module sha256_multiblock_core
    import sha256_pkg::*;
#(
    parameter int MAX_BLOCKS = 2,
    parameter int MSG_W      = MAX_BLOCKS * 512,
    parameter int LEN_W      = $clog2(MAX_BLOCKS * 512 + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MSG_W-1:0] msg,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    output logic             len_err,
    output logic [255:0]     digest
);

    localparam int BLK_W = $clog2(MAX_BLOCKS + 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             len_err_q, len_err_d;
    logic [255:0]     digest_q, digest_d;
    logic [5:0]       rnd_q, rnd_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] nblk_q, nblk_d;
    logic [MSG_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [0:7][31:0] hash_q, hash_d;
    logic [0:7][31:0] work_q, work_d;

    logic [MSG_W-1:0]  pad_buf;
    logic [0:15][31:0] load_words;
    logic [31:0]       w_t;
    logic [31:0]       t1;
    logic [31:0]       t2;
    logic [31:0]       nblk_calc;
    logic [63:0]       len64;
    logic              sched_load;
    logic              sched_shift;

    // Padded image of the captured message: message bits below the length,
    // the single marker bit at the length, and the 64-bit length in the last
    // 64 bits of the final block. Only written back to buf_q during PAD.
    always_comb begin
        pad_buf = '0;
        len64   = 64'(len_q);
        for (int i = 0; i < MSG_W; i++) begin
            if (i < int'(len_q)) begin
                pad_buf[i] = buf_q[i];
            end else if (i == int'(len_q)) begin
                pad_buf[i] = 1'b1;
            end
        end
        for (int b = 0; b < MAX_BLOCKS; b++) begin
            if (b == int'(nblk_q) - 1) begin
                for (int k = 0; k < 64; k++) begin
                    pad_buf[b * 512 + 448 + k] = len64[63 - k];
                end
            end
        end
    end

    // Big-endian word view of the current block: the first buffer bit of each
    // 32-bit group becomes the word's MSB.
    always_comb begin
        load_words = '0;
        if (int'(blk_q) < MAX_BLOCKS) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 32; k++) begin
                    load_words[j][31 - k] = buf_q[int'(blk_q) * 512 + j * 32 + k];
                end
            end
        end
    end

    // Compression round terms and the block count for a newly offered length.
    always_comb begin
        t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
           + K[rnd_q] + w_t;
        t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
        nblk_calc = (32'(msg_len) + 32'd64) / 32'd512 + 32'd1;
    end

    // Controller next-state logic. Outputs are computed for the state being
    // entered so that busy/done/len_err line up with the registered state.
    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        len_err_d   = 1'b0;
        digest_d    = digest_q;
        rnd_d       = rnd_q;
        blk_d       = blk_q;
        nblk_d      = nblk_q;
        buf_d       = buf_q;
        len_d       = len_q;
        hash_d      = hash_q;
        work_d      = work_q;
        sched_load  = 1'b0;
        sched_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (int'(msg_len) <= MSG_W - 65) begin
                        state_d = ST_PAD;
                        busy_d  = 1'b1;
                        buf_d   = msg;
                        len_d   = msg_len;
                        nblk_d  = BLK_W'(nblk_calc);
                    end else begin
                        state_d   = ST_ERR;
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            ST_PAD: begin
                state_d = ST_LOAD;
                busy_d  = 1'b1;
                buf_d   = pad_buf;
                blk_d   = '0;
                hash_d  = H_INIT;
            end
            ST_LOAD: begin
                state_d    = ST_ROUND;
                busy_d     = 1'b1;
                sched_load = 1'b1;
                work_d     = hash_q;
                rnd_d      = '0;
            end
            ST_ROUND: begin
                busy_d      = 1'b1;
                sched_shift = 1'b1;
                work_d      = {t1 + t2, work_q[0], work_q[1], work_q[2],
                               work_q[3] + t1, work_q[4], work_q[5], work_q[6]};
                rnd_d       = rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int i = 0; i < 8; i++) begin
                    hash_d[i] = hash_q[i] + work_q[i];
                end
                blk_d = blk_q + BLK_W'(1);
                if (blk_d == nblk_q) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    digest_d = hash_d;
                end else begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and output registers; reset aborts any hash in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            digest_q  <= '0;
            rnd_q     <= '0;
            blk_q     <= '0;
            nblk_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            digest_q  <= digest_d;
            rnd_q     <= rnd_d;
            blk_q     <= blk_d;
            nblk_q    <= nblk_d;
        end
    end

    // Datapath registers are always rewritten before use, so they need no reset.
    always_ff @(posedge clk) begin
        buf_q  <= buf_d;
        len_q  <= len_d;
        hash_q <= hash_d;
        work_q <= work_d;
    end

    sha256_msg_sched u_msg_sched (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (sched_load),
        .shift      (sched_shift),
        .load_words (load_words),
        .w_t        (w_t)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign len_err = len_err_q;
    assign digest  = digest_q;

endmodule
